// File: rtl/opc_pkg.sv
// +--------------------------------------------------------------------------+
// | opc_pkg : switch-wide constants, flit type codes and FSM state encoding |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package opc_pkg;

  localparam int PKTW    = 15;
  localparam int PORT    = 3;
  localparam int NIN_DEF = PORT + 1;
  localparam int FW      = PKTW + 1;

  localparam logic [1:0] FT_IDLE = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } opc_state_e;

  function automatic logic [1:0] flit_type(input logic [FW-1:0] f);
    return f[FW-1 -: 2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/opc_rrarb.sv
// +--------------------------------------------------------------------------+
// | rrarb : combinational round-robin arbiter, first requester at/after ptr |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rrarb #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt,
  output logic          vld
);

  logic [N-1:0] rot;
  int           off;
  int           sum;

  // Rotating a doubled copy puts req[(ptr+k) mod N] at bit k for any N.
  assign rot = N'({req, req} >> ptr);
  assign vld = |req;

  always_comb begin
    off = 0;
    sum = 0;
    gnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    sum = int'(ptr) + off;
    if (sum >= N) sum = sum - N;
    gnt = PW'(sum);
  end

endmodule

`default_nettype wire

// File: rtl/opc.sv
// +--------------------------------------------------------------------------+
// | opc : output port controller - arbitrates input buffers, acks the winner|
// |       flit by flit up to its tail and registers flits onto the link.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module opc
  import opc_pkg::*;
#(
  parameter int NIN = NIN_DEF,
  parameter int PID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIN-1:0]    req,
  input  logic [NIN*FW-1:0] pkti,
  output logic [NIN-1:0]    ack,
  output logic [FW-1:0]     pkto,
  input  logic              dfull,
  output logic              busy
);

  localparam int   PW      = (NIN > 1) ? $clog2(NIN) : 1;
  // A port index outside the switch never wins arbitration.
  localparam logic PORT_EN = (PID >= 0) && (PID < NIN);

  opc_state_e     state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  win_q, win_d;
  logic [FW-1:0]  pkto_q, pkto_d;
  logic [FW-1:0]  sel_flit;
  logic [NIN-1:0] win_ack;
  logic [PW-1:0]  arb_gnt;
  logic           arb_vld;

  rrarb #(
    .N  (NIN),
    .PW (PW)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .vld (arb_vld)
  );

  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < NIN; i++) begin
      if (win_q == PW'(i)) sel_flit = pkti[i*FW +: FW];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    pkto_d  = '0;
    win_ack = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld && PORT_EN) begin
          win_d   = arb_gnt;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // Un-acked cycles (backpressure or empty head) leave a bubble on the link.
        if (!dfull && flit_type(sel_flit) != FT_IDLE) begin
          win_ack = NIN'(1) << win_q;
          pkto_d  = sel_flit;
          if (flit_type(sel_flit) == FT_TAIL) begin
            state_d = ST_IDLE;
            ptr_d   = (win_q == PW'(NIN - 1)) ? '0 : win_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      pkto_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      pkto_q  <= pkto_d;
    end
  end

  assign ack  = win_ack;
  assign pkto = pkto_q;
  assign busy = (state_q == ST_XFER);

endmodule

`default_nettype wire

// File: tb/tb_opc.sv
// +--------------------------------------------------------------------------+
// | tb_opc : directed self-checking bench for the output port controller    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_opc;
  import opc_pkg::*;

  localparam int N = NIN_DEF;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*FW-1:0] pkti;
  logic [N-1:0]    ack;
  logic [FW-1:0]   pkto;
  logic            dfull;
  logic            busy;

  int n_chk  = 0;
  int n_fail = 0;

  opc #(
    .NIN (N),
    .PID (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .pkti  (pkti),
    .ack   (ack),
    .pkto  (pkto),
    .dfull (dfull),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flit {type, source, sequence number}; sequence starts at 1 so no flit is all-zero.
  function automatic logic [FW-1:0] fl(input int src, input int k, input int n);
    logic [1:0] t;
    t = (k == 0) ? FT_HEAD : ((k == n - 1) ? FT_TAIL : FT_BODY);
    return {t, 4'(src), 10'(k + 1)};
  endfunction

  task automatic set_in(input int i, input logic [FW-1:0] f);
    pkti[i*FW +: FW] = f;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Entered at the arbitration cycle with src's head presented; returns one
  // cycle after the tail edge.  A stall of st_n cycles is inserted before
  // flit st_at, either by dfull or by an empty head.
  task automatic do_pkt(input int src, input int n, input bit again,
                        input logic [FW-1:0] prev, input int st_at, input int st_n,
                        input bit st_empty, output logic [FW-1:0] tl);
    logic [FW-1:0] exp_out;
    logic [N-1:0]  onehot;
    onehot  = N'(1) << src;
    exp_out = prev;
    #3;
    check("arb_ack", ack, '0);
    check("arb_busy", busy, 1'b0);
    check("arb_pkto", pkto, exp_out);
    step;
    exp_out = '0;
    for (int k = 0; k < n; k++) begin
      if (k == st_at) begin
        for (int j = 0; j < st_n; j++) begin
          if (st_empty) set_in(src, '0);
          else dfull = 1'b1;
          #3;
          check("stall_ack", ack, '0);
          check("stall_busy", busy, 1'b1);
          check("stall_pkto", pkto, exp_out);
          step;
          exp_out = '0;
        end
        dfull = 1'b0;
        set_in(src, fl(src, k, n));
      end
      #3;
      check("xfer_ack", ack, onehot);
      check("xfer_busy", busy, 1'b1);
      check("xfer_pkto", pkto, exp_out);
      step;
      exp_out = fl(src, k, n);
      if (k + 1 < n) set_in(src, fl(src, k + 1, n));
    end
    if (again) begin
      set_in(src, fl(src, 0, n));
    end else begin
      set_in(src, '0);
      req[src] = 1'b0;
    end
    tl = exp_out;
  endtask

  task automatic idle_chk(input logic [FW-1:0] tl);
    #3;
    check("post_pkto", pkto, tl);
    check("post_busy", busy, 1'b0);
    check("post_ack", ack, '0);
    step;
  endtask

  task automatic do_reset;
    rst   = 1'b1;
    req   = '0;
    pkti  = '0;
    dfull = 1'b0;
    step;
    step;
    rst = 1'b0;
  endtask

  logic [FW-1:0] tl;

  initial begin
    rst   = 1'b1;
    req   = '0;
    pkti  = '0;
    dfull = 1'b0;
    #3;
    check("rst_ack", ack, '0);
    check("rst_pkto", pkto, '0);
    check("rst_busy", busy, 1'b0);
    do_reset;

    // Single requester, 3-flit packet from input 1; ptr moves to 2.
    req = 4'b0010;
    set_in(1, fl(1, 0, 3));
    do_pkt(1, 3, 1'b0, '0, -1, 0, 1'b0, tl);
    idle_chk(tl);
    // ptr==2 means input 2 beats input 0, then ptr wraps to input 0.
    req = 4'b0101;
    set_in(0, fl(0, 0, 2));
    set_in(2, fl(2, 0, 2));
    do_pkt(2, 2, 1'b0, '0, -1, 0, 1'b0, tl);
    do_pkt(0, 2, 1'b0, tl, -1, 0, 1'b0, tl);
    idle_chk(tl);

    // Async reset mid-packet with ptr at 1 beforehand.
    req = 4'b1000;
    set_in(3, fl(3, 0, 4));
    #3;
    check("t5_arb_ack", ack, '0);
    step;
    #3;
    check("t5_head_ack", ack, 4'b1000);
    step;
    set_in(3, fl(3, 1, 4));
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_ack", ack, '0);
    check("t5_rst_pkto", pkto, '0);
    check("t5_rst_busy", busy, 1'b0);
    req  = '0;
    pkti = '0;
    step;
    rst = 1'b0;
    // With ptr back at 0, input 0 wins over input 1.
    req = 4'b0011;
    set_in(0, fl(0, 0, 2));
    set_in(1, fl(1, 0, 2));
    do_pkt(0, 2, 1'b0, '0, -1, 0, 1'b0, tl);
    do_pkt(1, 2, 1'b0, tl, -1, 0, 1'b0, tl);
    idle_chk(tl);
    req = 4'b0100;
    set_in(2, fl(2, 0, 2));
    do_pkt(2, 2, 1'b0, '0, -1, 0, 1'b0, tl);
    idle_chk(tl);

    // Round robin between inputs 0 and 3: 0,3,0,3,0.
    do_reset;
    req = 4'b1001;
    set_in(0, fl(0, 0, 2));
    set_in(3, fl(3, 0, 2));
    do_pkt(0, 2, 1'b1, '0, -1, 0, 1'b0, tl);
    do_pkt(3, 2, 1'b1, tl, -1, 0, 1'b0, tl);
    do_pkt(0, 2, 1'b1, tl, -1, 0, 1'b0, tl);
    do_pkt(3, 2, 1'b0, tl, -1, 0, 1'b0, tl);
    do_pkt(0, 2, 1'b0, tl, -1, 0, 1'b0, tl);
    idle_chk(tl);

    // Backpressure for 2 cycles mid-body of a 4-flit packet.
    req = 4'b1000;
    set_in(3, fl(3, 0, 4));
    do_pkt(3, 4, 1'b0, '0, 2, 2, 1'b0, tl);
    idle_chk(tl);

    // Empty head for one cycle between body and tail.
    req = 4'b0100;
    set_in(2, fl(2, 0, 3));
    do_pkt(2, 3, 1'b0, '0, 2, 1, 1'b1, tl);
    idle_chk(tl);

    // Tail held off by dfull for 2 cycles.
    req = 4'b0010;
    set_in(1, fl(1, 0, 2));
    do_pkt(1, 2, 1'b0, '0, 1, 2, 1'b0, tl);
    idle_chk(tl);
    #3;
    check("final_pkto", pkto, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
